dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and sequencer for the shared single-port data memory. Port 0 is the CPU MEM stage and port 1 is the loader/debug requester. The block serialises their word reads and writes onto the DM's combinational-read, posedge-write interface, using round-robin priority. It also rejects misaligned and out-of-range addresses before they reach memory.

## Interface
Parameters:
- `ADDR_LIMIT`, default `32'h0000_1000`: byte size of the mapped DM. Any `addr >= ADDR_LIMIT` is an error.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `p0_req` / `p1_req`, in, 1: access request. Held high until the matching ack.
- `p0_we` / `p1_we`, in, 1: 1 = write, 0 = read. Held stable while req is high.
- `p0_addr` / `p1_addr`, in, 32: byte address.
- `p0_wdata` / `p1_wdata`, in, 32: write data.
- `p0_pc` / `p1_pc`, in, 32: PC tag used for the trace.
- `p0_ack` / `p1_ack`, out, 1: one-cycle completion pulse.
- `p0_err` / `p1_err`, out, 1: valid with ack. Set for a misaligned or out-of-range access.
- `p0_rdata` / `p1_rdata`, out, 32: read data, valid with ack. Held until the next ack on that port.
- `dm_a`, out, 32: DM address.
- `dm_wd`, out, 32: DM write data.
- `dm_re`, out, 1: DM read enable.
- `dm_we`, out, 1: DM write enable.
- `dm_pc`, out, 32: PC tag forwarded to the DM.
- `dm_rd`, in, 32: DM combinational read data.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
FSM states: IDLE, ACC, RESP.
- **IDLE:**
  - Samples `p0_req` and `p1_req`.
  - If exactly one request is high, that port wins.
  - If both are high, the port not equal to `last` wins.
  - On a grant, the block latches the winner's we/addr/wdata/pc and the port index, sets `last` = winner, and goes to ACC.
- **ACC:** exactly one cycle. DM outputs are driven from the latched request.
  - Valid read: `dm_re`=1, `dm_we`=0. `dm_rd` is captured into the winner's rdata register at the end of the cycle.
  - Valid write: `dm_we`=1, `dm_re`=0. The DM commits on the closing edge.
  - Error (`addr[1:0]!=0` or `addr>=ADDR_LIMIT`): `dm_re`=`dm_we`=0, the winner's rdata is loaded with 0, and the error flag is set.
  - Always goes to RESP.
- **RESP:** the winner's ack is 1 and its err shows the flag. Always returns to IDLE.
  - The requester deasserts req during this cycle.
  - A req that is still high in the next IDLE is treated as a new access.
- Outside ACC: `dm_re`=`dm_we`=0. `dm_a`, `dm_wd` and `dm_pc` show the latched values; they are don't-care for the DM.
- Fairness: with both ports requesting continuously, grants alternate strictly 0,1,0,1. No port waits more than one foreign access (3 cycles).
- Reset:
  - All outputs are 0 and state is IDLE.
  - `last`=1, so port 0 wins the first tie.
  - Latched request registers are 0.
- Reset asserted mid-ACC: `dm_we` drops asynchronously, the write is dropped and no ack is issued. The requester re-issues after reset.

## Timing
- Request seen in IDLE at edge t: ACC during cycle t+1, ack/err/rdata valid during t+2, IDLE at t+3.
- Latency is 2 cycles from grant to ack. Peak throughput is one access per 3 cycles.
- Ack is never asserted on both ports in the same cycle.
- A req that rises in ACC or RESP waits for the next IDLE.
- Changing a port's we/addr/wdata while its req is high is illegal. Values are latched at grant, so later changes have no effect.

## Configuration
- `DM_ARB_TRACE_EN` defined:
  - On every edge that closes a valid-write ACC with `reset` high, prints `$display("%d@%h: *%h <= %h", $time, pc, addr, wdata)` from the latched values.
  - On an error ACC, prints the same format prefixed by `ERR`.
- Undefined: no display statements. `p*_pc` still propagate to `dm_pc`. RTL behaviour is otherwise identical.

## Structure
- Package `dm_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ACC`, `ST_RESP`);
  - port index constants `PORT_CPU`=0 and `PORT_DBG`=1;
  - the default `ADDR_LIMIT` constant.
- Sub-module `rr_arb2`: combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - `dm_arbiter` owns the `last` register and updates it on grant.

## Test plan
- **Port 0 write:** `p0_req` with write `addr=0x10`, `wdata=0xDEADBEEF`, `pc=0x3000` → `dm_we`=1 only in cycle t+1; `p0_ack`=1, `p0_err`=0 in t+2; trace line prints with the macro defined.
- **Port 1 readback:** `p1_req` read of `0x10` after the above → `p1_rdata=0xDEADBEEF` with `p1_ack` at t+2; `p0_ack` stays 0.
- **Contention:** both ports request from reset and stay high → ack order p0, p1, p0, p1 at cycles t+2, t+5, t+8, t+11.
- **Errors:** p0 at `addr=0x13`, then p0 at `addr=0x1000` → `dm_re`=`dm_we`=0 throughout; ack with `err`=1 and `rdata=0`; DM contents unchanged.
- **Reset mid-ACC:** `reset` driven low during the ACC of a write to `0x20` → `dm_we` falls immediately; no ack; after release, state IDLE, `busy`=0, first tie goes to port 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - dm_arb_state_e : sequencer states (IDLE -> ACC -> RESP -> IDLE)
//   - PORT_CPU/PORT_DBG : requester port indices
//   - ADDR_LIMIT_DEFAULT : default byte size of the mapped data memory
//   - addr_is_bad() : misaligned / out-of-range address test
// ----------------------------------------------------------------------------
package dm_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RESP = 2'd2
   } dm_arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_1000;

   // A word access must be 4-byte aligned and lie below the mapped size.
   function automatic logic addr_is_bad(input logic [31:0] addr,
                                        input logic [31:0] limit);
      return (addr[1:0] != 2'b00) || (addr >= limit);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker. On a tie the port that did not
// win last time is chosen; the caller owns and updates the 'last' register.
// Ports:
//   req[1:0]  : request from port 0 / port 1
//   last      : index of the previous winner
//   gnt_valid : at least one request present
//   gnt_idx   : index of the chosen port (meaningful when gnt_valid)
// ----------------------------------------------------------------------------
module rr_arb2
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   // Pick a winner; a tie goes to the port that is not 'last'.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = PORT_CPU;
      case (req)
         2'b01: begin
            gnt_valid = 1'b1;
            gnt_idx   = PORT_CPU;
         end
         2'b10: begin
            gnt_valid = 1'b1;
            gnt_idx   = PORT_DBG;
         end
         2'b11: begin
            gnt_valid = 1'b1;
            gnt_idx   = ~last;
         end
         default: begin
            gnt_valid = 1'b0;
            gnt_idx   = PORT_CPU;
         end
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
// Two-port arbiter/sequencer for the shared single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the loader/debug requester. Each access
// takes IDLE (grant) -> ACC (drive DM) -> RESP (ack) with round-robin priority.
// Misaligned or out-of-range accesses never reach the DM and complete with err.
// Optional macro: DM_ARB_TRACE_EN prints a trace line for every committed
// write and every error access.
// Ports:
//   clk, reset (async, active-low)
//   pX_req/we/addr/wdata/pc : request from port X (held until pX_ack)
//   pX_ack/err/rdata        : one-cycle completion, error flag, read data
//   dm_a/wd/re/we/pc, dm_rd : DM interface (comb read, posedge write)
//   busy                    : sequencer is not idle
// ----------------------------------------------------------------------------
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [31:0] p0_pc,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [31:0] p1_pc,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [31:0] dm_a,
   output logic [31:0] dm_wd,
   output logic        dm_re,
   output logic        dm_we,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_rd,
   output logic        busy
);

   dm_arb_state_e state_r, state_nxt_s;

   logic        last_r;
   logic        gnt_valid_s, gnt_idx_s;
   logic        grant_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s, sel_wdata_s, sel_pc_s;
   logic        sel_bad_s;

   logic        we_r;
   logic [31:0] addr_r, wdata_r, pc_r;
   logic        idx_r;
   logic        err_flag_r;
   logic        dm_re_r, dm_we_r;
   logic [1:0]  ack_r, err_r;
   logic [31:0] rdata0_r, rdata1_r;
   logic        rdata_upd_s;
   logic [31:0] rdata_nxt_s;

   rr_arb2 u_rr (
      .req       ({p1_req, p0_req}),
      .last      (last_r),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (gnt_idx_s)
   );

   // Winner's request fields and grant qualification.
   always_comb begin
      grant_s     = (state_r == ST_IDLE) && gnt_valid_s;
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
      sel_pc_s    = p0_pc;
      if (gnt_idx_s == PORT_DBG) begin
         sel_we_s    = p1_we;
         sel_addr_s  = p1_addr;
         sel_wdata_s = p1_wdata;
         sel_pc_s    = p1_pc;
      end else begin
         sel_we_s    = p0_we;
         sel_addr_s  = p0_addr;
         sel_wdata_s = p0_wdata;
         sel_pc_s    = p0_pc;
      end
      sel_bad_s = addr_is_bad(sel_addr_s, ADDR_LIMIT);
   end

   // Next-state logic of the IDLE/ACC/RESP sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_valid_s) begin
               state_nxt_s = ST_ACC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACC:  state_nxt_s = ST_RESP;
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latch the winning request at grant; 'last' starts at 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_r     <= 1'b1;
         we_r       <= 1'b0;
         addr_r     <= 32'h0;
         wdata_r    <= 32'h0;
         pc_r       <= 32'h0;
         idx_r      <= 1'b0;
         err_flag_r <= 1'b0;
      end else if (grant_s) begin
         last_r     <= gnt_idx_s;
         we_r       <= sel_we_s;
         addr_r     <= sel_addr_s;
         wdata_r    <= sel_wdata_s;
         pc_r       <= sel_pc_s;
         idx_r      <= gnt_idx_s;
         err_flag_r <= sel_bad_s;
      end
   end

   // DM strobes are registered at grant so they are high exactly during ACC
   // and drop asynchronously with reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dm_re_r <= 1'b0;
         dm_we_r <= 1'b0;
      end else begin
         dm_re_r <= grant_s && !sel_we_s && !sel_bad_s;
         dm_we_r <= grant_s &&  sel_we_s && !sel_bad_s;
      end
   end

   // Read data load: DM word for a valid read, zero for an error, untouched for a write.
   always_comb begin
      rdata_upd_s = (state_r == ST_ACC) && (err_flag_r || !we_r);
      if (err_flag_r) begin
         rdata_nxt_s = 32'h0;
      end else begin
         rdata_nxt_s = dm_rd;
      end
   end

   // Completion pulse and error flag for the winner, issued on leaving ACC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r <= 2'b00;
         err_r <= 2'b00;
      end else if (state_r == ST_ACC) begin
         ack_r        <= 2'b00;
         err_r        <= 2'b00;
         ack_r[idx_r] <= 1'b1;
         err_r[idx_r] <= err_flag_r;
      end else begin
         ack_r <= 2'b00;
         err_r <= 2'b00;
      end
   end

   // Per-port read data registers, held until the next ack on that port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0_r <= 32'h0;
         rdata1_r <= 32'h0;
      end else if (rdata_upd_s) begin
         if (idx_r == PORT_DBG) begin
            rdata1_r <= rdata_nxt_s;
         end else begin
            rdata0_r <= rdata_nxt_s;
         end
      end
   end

`ifdef DM_ARB_TRACE_EN
   // Trace of committed writes and rejected accesses from the latched request.
   always @(posedge clk) begin
      if (reset && (state_r == ST_ACC)) begin
         if (err_flag_r) begin
            $display("ERR%d@%h: *%h <= %h", $time, pc_r, addr_r, wdata_r);
         end else if (we_r) begin
            $display("%d@%h: *%h <= %h", $time, pc_r, addr_r, wdata_r);
         end
      end
   end
`endif

   assign dm_a     = addr_r;
   assign dm_wd    = wdata_r;
   assign dm_pc    = pc_r;
   assign dm_re    = dm_re_r;
   assign dm_we    = dm_we_r;
   assign p0_ack   = ack_r[0];
   assign p1_ack   = ack_r[1];
   assign p0_err   = err_r[0];
   assign p1_err   = err_r[1];
   assign p0_rdata = rdata0_r;
   assign p1_rdata = rdata1_r;
   assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed scenarios followed by randomized traffic on both ports. A word
// memory model sits on the DM interface; a separate reference memory is
// updated at transaction level and predicts err/rdata for each ack.
// ----------------------------------------------------------------------------
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0, p0_pc = 32'h0;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0, p1_pc = 32'h0;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] dm_a, dm_wd, dm_pc, dm_rd;
   logic        dm_re, dm_we, busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:1023] = '{default: 32'h0};
   logic [31:0] ref_mem [0:1023];

   logic        pend [2];
   int          wait_c [2];
   logic        sh_we [2];
   logic [31:0] sh_addr [2];
   logic [31:0] sh_wd [2];

   dm_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_pc(p0_pc),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_pc(p1_pc),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .dm_a(dm_a), .dm_wd(dm_wd), .dm_re(dm_re), .dm_we(dm_we), .dm_pc(dm_pc),
      .dm_rd(dm_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, posedge write.
   always @(posedge clk) begin
      if (dm_we) mem[dm_a[11:2]] <= dm_wd;
   end
   assign dm_rd = mem[dm_a[11:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic rq, input logic we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] pc);
      if (p == 0) begin
         p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = wd; p0_pc = pc;
      end else begin
         p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = wd; p1_pc = pc;
      end
   endtask

   task automatic do_reset;
      reset = 1'b0;
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick;
      tick;
      reset = 1'b1;
   endtask

   function automatic logic model_bad(input logic [31:0] a);
      return ((a % 4) != 0) || (a >= 32'd4096);
   endfunction

   // One cycle of random traffic: check acks against the reference memory,
   // then optionally launch new requests.
   task automatic service(input bit allow_new);
      logic ack_v [2];
      logic err_v [2];
      logic [31:0] rd_v [2];
      logic exp_bad;
      int r;
      tick;
      ack_v[0] = p0_ack; ack_v[1] = p1_ack;
      err_v[0] = p0_err; err_v[1] = p1_err;
      rd_v[0] = p0_rdata; rd_v[1] = p1_rdata;
      chk("ack_exclusive", 32'(p0_ack & p1_ack), 32'h0);
      for (int p = 0; p < 2; p++) begin
         if (pend[p]) wait_c[p]++;
         if (ack_v[p]) begin
            chk("ack_without_req", 32'(pend[p]), 32'h1);
            exp_bad = model_bad(sh_addr[p]);
            chk("rnd_err", 32'(err_v[p]), 32'(exp_bad));
            chk("rnd_wait_bound", 32'(wait_c[p] <= 5), 32'h1);
            if (exp_bad) begin
               chk("rnd_err_rdata", rd_v[p], 32'h0);
            end else if (sh_we[p]) begin
               ref_mem[sh_addr[p] / 4] = sh_wd[p];
            end else begin
               chk("rnd_rdata", rd_v[p], ref_mem[sh_addr[p] / 4]);
            end
            pend[p] = 1'b0;
            set_port(p, 1'b0, sh_we[p], sh_addr[p], sh_wd[p], 32'h0);
         end else if (!pend[p] && allow_new && ($urandom_range(1, 0) == 1)) begin
            r = $urandom_range(7, 0);
            if (r == 0)
               sh_addr[p] = (32'($urandom_range(15, 0)) * 4) + 32'($urandom_range(3, 1));
            else if (r == 1)
               sh_addr[p] = 32'h0000_1000 + 32'($urandom_range(15, 0)) * 4;
            else
               sh_addr[p] = 32'($urandom_range(15, 0)) * 4;
            sh_we[p] = 1'($urandom_range(1, 0));
            sh_wd[p] = $urandom;
            pend[p] = 1'b1;
            wait_c[p] = 0;
            set_port(p, 1'b1, sh_we[p], sh_addr[p], sh_wd[p], $urandom);
         end
      end
   endtask

   initial begin
      logic [11:0] ack0_v, ack1_v;
      int diff;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

      // Reset state
      do_reset;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ack", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'h0);
      chk("rst_strobes", 32'({dm_re, dm_we}), 32'h0);
      chk("rst_dm_a", dm_a, 32'h0);
      chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);

      // Port 0 write
      set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h3000);
      tick;
      chk("wr_acc_we", 32'(dm_we), 32'h1);
      chk("wr_acc_re", 32'(dm_re), 32'h0);
      chk("wr_acc_addr", dm_a, 32'h10);
      chk("wr_acc_wd", dm_wd, 32'hDEADBEEF);
      chk("wr_acc_pc", dm_pc, 32'h3000);
      chk("wr_acc_ack", 32'(p0_ack), 32'h0);
      chk("wr_acc_busy", 32'(busy), 32'h1);
      tick;
      chk("wr_resp_ack", 32'(p0_ack), 32'h1);
      chk("wr_resp_err", 32'(p0_err), 32'h0);
      chk("wr_resp_we", 32'(dm_we), 32'h0);
      p0_req = 1'b0;
      ref_mem[4] = 32'hDEADBEEF;
      tick;
      chk("wr_idle_ack", 32'(p0_ack), 32'h0);
      chk("wr_idle_busy", 32'(busy), 32'h0);
      chk("wr_mem", mem[4], 32'hDEADBEEF);

      // Port 1 readback
      set_port(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h4000);
      tick;
      chk("rd_acc_re", 32'(dm_re), 32'h1);
      chk("rd_acc_we", 32'(dm_we), 32'h0);
      tick;
      chk("rd_resp_ack1", 32'(p1_ack), 32'h1);
      chk("rd_resp_ack0", 32'(p0_ack), 32'h0);
      chk("rd_rdata", p1_rdata, 32'hDEADBEEF);
      chk("rd_err", 32'(p1_err), 32'h0);
      p1_req = 1'b0;
      tick;

      // Errors: load p0 rdata first so the zeroing is visible
      set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h5000);
      tick; tick;
      chk("pre_err_rdata", p0_rdata, 32'hDEADBEEF);
      p0_req = 1'b0;
      tick;
      set_port(0, 1'b1, 1'b1, 32'h13, 32'h12345678, 32'h5004);
      tick;
      chk("mis_acc_strobes", 32'({dm_re, dm_we}), 32'h0);
      tick;
      chk("mis_ack", 32'(p0_ack), 32'h1);
      chk("mis_err", 32'(p0_err), 32'h1);
      chk("mis_rdata", p0_rdata, 32'h0);
      p0_req = 1'b0;
      tick;
      set_port(0, 1'b1, 1'b1, 32'h1000, 32'h55AA55AA, 32'h5008);
      tick;
      chk("oor_acc_strobes", 32'({dm_re, dm_we}), 32'h0);
      tick;
      chk("oor_ack", 32'(p0_ack), 32'h1);
      chk("oor_err", 32'(p0_err), 32'h1);
      p0_req = 1'b0;
      tick;
      chk("err_mem_w4", mem[4], 32'hDEADBEEF);
      chk("err_mem_w0", mem[0], 32'h0);

      // Contention from reset: strict alternation, acks every 3 cycles
      do_reset;
      set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
      set_port(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      ack0_v = 12'h0;
      ack1_v = 12'h0;
      for (int k = 1; k <= 12; k++) begin
         tick;
         ack0_v[k-1] = p0_ack;
         ack1_v[k-1] = p1_ack;
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      chk("cont_p0_acks", 32'(ack0_v), 32'h082);
      chk("cont_p1_acks", 32'(ack1_v), 32'h410);
      tick; tick; tick;

      // Reset during the ACC of a write
      set_port(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h6000);
      tick;
      chk("rma_acc_we", 32'(dm_we), 32'h1);
      reset = 1'b0;
      #1;
      chk("rma_we_async", 32'(dm_we), 32'h0);
      chk("rma_busy", 32'(busy), 32'h0);
      p0_req = 1'b0;
      tick;
      chk("rma_no_ack", 32'({p0_ack, p1_ack}), 32'h0);
      chk("rma_mem", mem[8], 32'h0);
      reset = 1'b1;
      #1;
      chk("rma_post_busy", 32'(busy), 32'h0);
      set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
      set_port(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      tick;
      chk("rma_tie_addr", dm_a, 32'h10);
      tick;
      chk("rma_tie_ack0", 32'(p0_ack), 32'h1);
      chk("rma_tie_ack1", 32'(p1_ack), 32'h0);
      p0_req = 1'b0;
      tick; tick; tick;
      chk("rma_p1_ack", 32'(p1_ack), 32'h1);
      p1_req = 1'b0;
      tick;

      // Randomized traffic against the reference memory
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0;
         wait_c[p] = 0;
         sh_we[p] = 1'b0;
         sh_addr[p] = 32'h0;
         sh_wd[p] = 32'h0;
      end
      for (int c = 0; c < 800; c++) service(1'b1);
      for (int c = 0; c < 20; c++) service(1'b0);
      chk("drain_p0", 32'(pend[0]), 32'h0);
      chk("drain_p1", 32'(pend[1]), 32'h0);

      diff = 0;
      for (int i = 0; i < 1024; i++) begin
         if (mem[i] !== ref_mem[i]) diff++;
      end
      chk("final_mem_diff", 32'(diff), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
